// File: rtl/sensor_responder_pkg.sv
// Shared constants for the parking-sensor SPI responder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sensor_responder_pkg;

    // Default frame geometry: 3 leading zeros, 8-bit sample, 5 trailing zeros.
    localparam int DFLT_FRAME_BITS = 16;
    localparam int DFLT_DATA_BITS  = 8;
    localparam int DFLT_LEAD_ZEROS = 3;

    // clk must run at least this many times faster than SCLK for the
    // oversampling synchronisers to see every SCLK level.
    localparam int MIN_CLK_RATIO = 8;

    // Responder state encoding.
    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;

endpackage

// File: rtl/sensor_responder_if.sv
// SPI link between the sensor-path master and the emulated sensor.
// Latency: n/a (wires only).
// Backpressure: none; SS/SCLK pace the transfer.
// Signals: SS (active-low select), SCLK (idle low), MOSI, MISO.
interface sensor_responder_if;
    logic SS;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS, output SCLK, output MOSI, input MISO);
    modport slave  (input SS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/sensor_responder_spi_sync_edge.sv
// Two-flop synchroniser for an async SPI line plus a third copy for edges.
// Latency: level 2 clk after the input; rise/fall pulse valid in the following cycle.
// Backpressure: none.
// Ports: clk, rst_n (sync, active-low), d (async in), level, rise, fall.
module sensor_responder_spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= d;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~sync_d;
    assign fall  = ~sync & sync_d;

endmodule

// File: rtl/sensor_responder.sv
// SPI mode-0 responder emulating the parking sensor: sends {zeros, sample, zeros}, captures MOSI.
// Latency: first MISO bit 3 clk after the raw SS fall; frame_done/frame_error 3 clk after raw SS rise.
// Backpressure: none; the master paces frames, sample_valid is always accepted.
// Ports: clk, rst_n, spi (slave modport), sample_in/sample_valid, busy, frame_done, frame_error, rx_data.
module sensor_responder
    import sensor_responder_pkg::*;
#(
    parameter int FRAME_BITS = DFLT_FRAME_BITS,
    parameter int DATA_BITS  = DFLT_DATA_BITS,
    parameter int LEAD_ZEROS = DFLT_LEAD_ZEROS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sensor_responder_if.slave     spi,
    input  logic [DATA_BITS-1:0]  sample_in,
    input  logic                  sample_valid,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [FRAME_BITS-1:0] rx_data
);

    localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
    // Counter must reach FRAME_BITS+1 so a long frame stays distinguishable.
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

    logic                  ss_sync, ss_rise, ss_fall;
    logic                  sclk_level_unused, sclk_rise, sclk_fall;
    logic                  mosi_meta, mosi_sync;
    logic [1:0]            state;
    logic [DATA_BITS-1:0]  hold;
    logic [CNT_W-1:0]      cnt;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [FRAME_BITS-1:0] tx_load;

    sensor_responder_spi_sync_edge u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi.SS),
        .level (ss_sync),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    sensor_responder_spi_sync_edge u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi.SCLK),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // MOSI has the same 2-flop delay as SCLK, so it lines up with sclk_rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= spi.MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    // A sample arriving on the load cycle goes straight into the frame.
    assign tx_load = FRAME_BITS'(sample_valid ? sample_in : hold) << TRAIL_ZEROS;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_WAIT_IDLE;
            hold        <= '0;
            cnt         <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (sample_valid) begin
                hold <= sample_in;
            end
            case (state)
                // Wait for SS high so a frame cut by reset is never half-served.
                ST_WAIT_IDLE: begin
                    if (ss_sync) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (ss_fall) begin
                        tx_shift <= tx_load;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // SS rise takes priority over any SCLK edge in the same cycle.
                    if (ss_rise) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                        if (cnt == CNT_FULL) begin
                            rx_data    <= rx_shift;
                            frame_done <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync};
                            if (cnt != CNT_MAX) begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: state <= ST_WAIT_IDLE;
            endcase
        end
    end

    assign spi.MISO = busy & tx_shift[FRAME_BITS-1];

endmodule

// File: tb/tb_sensor_responder.sv
// Bench for sensor_responder: drives SPI frames and checks MISO, pulses and rx_data.
// Latency: n/a.
// Backpressure: n/a.
module tb_sensor_responder;
    import sensor_responder_pkg::*;

    typedef struct {
        logic [31:0] miso;
        logic [15:0] rx;
        int          done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic        busy;
    logic        frame_done;
    logic        frame_error;
    logic [15:0] rx_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    exp_t exp_q[$];

    sensor_responder_if bus ();

    sensor_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi          (bus),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_error  (frame_error),
        .rx_data      (rx_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_error) err_cnt++;
        if (frame_done && frame_error) both_cnt++;
    end

    // Frame stream: LEAD zeros, sample MSB first, then zeros forever.
    function automatic logic [31:0] exp_miso(input logic [7:0] s, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (i >= 3 && i < 11) r[n-1-i] = s[10-i];
        end
        return r;
    endfunction

    task automatic set_sample(input logic [7:0] v);
        @(negedge clk);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Master side of one frame; MISO sampled just before each SCLK rise.
    task automatic spi_xfer(input int nbits, input logic [31:0] mosi_word,
                            input int lead, input int half,
                            input bit bp_en, input logic [7:0] bp_val,
                            input bit mid_en, input logic [7:0] mid_val,
                            input int rst_at,
                            output logic [31:0] miso_bits, output bit busy_ok,
                            output logic [17:0] rst_obs);
        miso_bits = '0;
        busy_ok   = 1'b1;
        rst_obs   = '1;
        bus.MOSI  = mosi_word[nbits-1];
        @(negedge clk);
        bus.SS = 1'b0;
        for (int j = 1; j <= lead; j++) begin
            @(negedge clk);
            if (bp_en && j == 2) begin
                sample_in    = bp_val;
                sample_valid = 1'b1;
            end
            if (bp_en && j == 3) sample_valid = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_obs = {bus.MISO, busy, rx_data};
                rst_n = 1'b1;
            end
            if (mid_en && i == 8) begin
                sample_in    = mid_val;
                sample_valid = 1'b1;
                @(negedge clk);
                sample_valid = 1'b0;
            end
            repeat (half) @(negedge clk);
            miso_bits[nbits-1-i] = bus.MISO;
            if (busy !== 1'b1) busy_ok = 1'b0;
            bus.SCLK = 1'b1;
            repeat (half) @(negedge clk);
            bus.SCLK = 1'b0;
            if (i < nbits - 1) bus.MOSI = mosi_word[nbits-2-i];
        end
        repeat (half) @(negedge clk);
        bus.SS = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.SS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
        sample_valid = 1'b0; sample_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", bus.MISO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", frame_error); end
        checks++; if (rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx got %h exp 0000", rx_data); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_good_frame();
        exp_t e; logic [31:0] mb; bit bok; logic [17:0] ro; int d0, e0;
        set_sample(8'hA5);
        exp_q.push_back('{miso: exp_miso(8'hA5, 16), rx: 16'h1234, done: 1});
        d0 = done_cnt; e0 = err_cnt;
        spi_xfer(16, 32'h1234, 10, 50, 0, 8'h0, 0, 8'h0, -1, mb, bok, ro);
        e = exp_q.pop_front();
        checks++; if (mb !== e.miso) begin errors++; $display("FAIL good_miso got %h exp %h", mb, e.miso); end
        checks++; if (done_cnt - d0 !== e.done) begin errors++; $display("FAIL good_done got %0d exp %0d", done_cnt - d0, e.done); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL good_err got %0d exp 0", err_cnt - e0); end
        checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL good_rx got %h exp %h", rx_data, e.rx); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL good_busy_during got %b exp 1", bok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_bypass();
        exp_t e; logic [31:0] mb; bit bok; logic [17:0] ro; int d0;
        logic [7:0]  smp [2];
        logic [15:0] mos [2];
        smp[0] = 8'h3C; smp[1] = 8'hFF;
        mos[0] = 16'h0F0F; mos[1] = 16'hF00D;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back('{miso: exp_miso(smp[f], 16), rx: mos[f], done: 1});
            d0 = done_cnt;
            spi_xfer(16, {16'h0, mos[f]}, 10, 50, f == 0, 8'h3C, f == 0, 8'hFF, -1, mb, bok, ro);
            e = exp_q.pop_front();
            checks++; if (mb !== e.miso) begin errors++; $display("FAIL bypass%0d_miso got %h exp %h", f, mb, e.miso); end
            checks++; if (done_cnt - d0 !== e.done) begin errors++; $display("FAIL bypass%0d_done got %0d exp %0d", f, done_cnt - d0, e.done); end
            checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL bypass%0d_rx got %h exp %h", f, rx_data, e.rx); end
        end
    endtask

    // Short (10) and long (18) frames: both must error and leave rx_data alone.
    task automatic test_bad_length();
        exp_t e; logic [31:0] mb; bit bok; logic [17:0] ro; int d0, e0;
        int nb [2];
        nb[0] = 10; nb[1] = 18;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back('{miso: exp_miso(8'hFF, nb[f]), rx: 16'hF00D, done: 0});
            d0 = done_cnt; e0 = err_cnt;
            spi_xfer(nb[f], 32'h0003_5A5A, 10, 50, 0, 8'h0, 0, 8'h0, -1, mb, bok, ro);
            e = exp_q.pop_front();
            checks++; if (mb !== e.miso) begin errors++; $display("FAIL len%0d_miso got %h exp %h", nb[f], mb, e.miso); end
            checks++; if (done_cnt - d0 !== e.done) begin errors++; $display("FAIL len%0d_done got %0d exp %0d", nb[f], done_cnt - d0, e.done); end
            checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL len%0d_err got %0d exp 1", nb[f], err_cnt - e0); end
            checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL len%0d_rx got %h exp %h", nb[f], rx_data, e.rx); end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e; logic [31:0] mb; bit bok; logic [17:0] ro; int d0, e0;
        set_sample(8'h81);
        // Bits 0..5 go out normally; after reset the responder stays silent.
        exp_q.push_back('{miso: exp_miso(8'h81, 16) & 32'h0000_FC00, rx: 16'h0, done: 0});
        d0 = done_cnt; e0 = err_cnt;
        spi_xfer(16, 32'h7777, 10, 50, 0, 8'h0, 0, 8'h0, 6, mb, bok, ro);
        e = exp_q.pop_front();
        checks++; if (mb !== e.miso) begin errors++; $display("FAIL rstmid_miso got %h exp %h", mb, e.miso); end
        checks++; if (ro !== 18'h0) begin errors++; $display("FAIL rstmid_outputs got %h exp 00000", ro); end
        checks++; if (done_cnt - d0 !== e.done) begin errors++; $display("FAIL rstmid_done got %0d exp 0", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rstmid_err got %0d exp 0", err_cnt - e0); end
        checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL rstmid_rx got %h exp %h", rx_data, e.rx); end
        set_sample(8'h5A);
        exp_q.push_back('{miso: exp_miso(8'h5A, 16), rx: 16'hCAFE, done: 1});
        d0 = done_cnt;
        spi_xfer(16, 32'hCAFE, 10, 50, 0, 8'h0, 0, 8'h0, -1, mb, bok, ro);
        e = exp_q.pop_front();
        checks++; if (mb !== e.miso) begin errors++; $display("FAIL rstnext_miso got %h exp %h", mb, e.miso); end
        checks++; if (done_cnt - d0 !== e.done) begin errors++; $display("FAIL rstnext_done got %0d exp 1", done_cnt - d0); end
        checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL rstnext_rx got %h exp %h", rx_data, e.rx); end
    endtask

    // Minimum clk:SCLK ratio, SS fall to first SCLK rise 8 clk apart.
    task automatic test_edge_timing();
        exp_t e; logic [31:0] mb; bit bok; logic [17:0] ro; int d0;
        set_sample(8'hC3);
        exp_q.push_back('{miso: exp_miso(8'hC3, 16), rx: 16'hBEEF, done: 1});
        d0 = done_cnt;
        spi_xfer(16, 32'hBEEF, MIN_CLK_RATIO / 2, MIN_CLK_RATIO / 2, 0, 8'h0, 0, 8'h0, -1, mb, bok, ro);
        e = exp_q.pop_front();
        checks++; if (mb !== e.miso) begin errors++; $display("FAIL edge_miso got %h exp %h", mb, e.miso); end
        checks++; if (done_cnt - d0 !== e.done) begin errors++; $display("FAIL edge_done got %0d exp 1", done_cnt - d0); end
        checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL edge_rx got %h exp %h", rx_data, e.rx); end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_and_error_overlap got %0d exp 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bypass();
        test_bad_length();
        test_reset_mid_frame();
        test_edge_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
